usb_tx_encoder: RTL

USB_TX_ENCODER -- requirements
Module: usb_tx_encoder

---
 rtl/usb_tx_pkg.sv | 27 ++
 rtl/usb_bit_stuffer.sv | 28 ++
 rtl/usb_tx_encoder.sv | 94 +++++++++
 3 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit encoder.
package usb_tx_pkg;

  // Encoder FSM states
  typedef enum logic [2:0] {
    IDLE,
    DATA,
    STUFF,
    EOP_SE0_1,
    EOP_SE0_2,
    EOP_J
  } state_t;

  // Number of consecutive 1s after which a stuff bit is inserted
  localparam int STUFF_LIMIT = 6;

  // Line levels packed as {d_plus, d_minus}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  // NRZI transition: J <-> K. Only called while the line is J or K.
  function automatic logic [1:0] line_toggle(input logic [1:0] line);
    return (line == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage

// File: rtl/usb_bit_stuffer.sv
// Consecutive-ones counter; flags when the bit being consumed is the sixth 1.
module usb_bit_stuffer
  import usb_tx_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic inc,
  output logic stuff_req
);

  logic [2:0] ones_cnt;

  // The consumed 1 completes a run of STUFF_LIMIT ones
  assign stuff_req = inc && (ones_cnt == 3'(STUFF_LIMIT - 1));

  // Count ones; saturate at the limit so the counter can never pass it
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ones_cnt <= 3'd0;
    end else if (clr) begin
      ones_cnt <= 3'd0;
    end else if (inc && (ones_cnt != 3'(STUFF_LIMIT))) begin
      ones_cnt <= ones_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed style transmit encoder: NRZI, bit stuffing and EOP generation.
module usb_tx_encoder
  import usb_tx_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic shift_enable,
  input  logic tx_start,
  input  logic tx_bit,
  input  logic tx_last,
  output logic d_plus,
  output logic d_minus,
  output logic bit_take,
  output logic busy,
  output logic eop_done
);

  state_t     state;
  logic [1:0] line_reg;
  logic       last_pending;
  logic       stuff_req;
  logic       cnt_clr;
  logic       cnt_inc;

  assign d_plus  = line_reg[1];
  assign d_minus = line_reg[0];

  // Strobe-qualified pulses; forced low while reset is asserted
  assign bit_take = n_rst && shift_enable && (state == DATA);
  assign eop_done = n_rst && shift_enable && (state == EOP_J);
  assign busy     = n_rst && (state != IDLE);

  // Counter clears on packet start, on any transmitted 0 and on a stuff bit
  assign cnt_clr = shift_enable && (((state == IDLE) && tx_start) ||
                                    ((state == DATA) && !tx_bit) ||
                                    (state == STUFF));
  assign cnt_inc = bit_take && tx_bit;

  usb_bit_stuffer u_stuffer (
    .clk       (clk),
    .n_rst     (n_rst),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
    .stuff_req (stuff_req)
  );

  // Encoder FSM: each state performs its line action on its own strobe
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= IDLE;
      line_reg     <= LINE_J;
      last_pending <= 1'b0;
    end else if (shift_enable) begin
      case (state)
        IDLE: begin
          line_reg <= LINE_J;
          if (tx_start) state <= DATA;
        end
        DATA: begin
          if (!tx_bit) line_reg <= line_toggle(line_reg);
          if (stuff_req) begin
            // Stuff bit takes priority; defer end-of-packet until after it
            state        <= STUFF;
            last_pending <= tx_last;
          end else if (tx_last) begin
            state <= EOP_SE0_1;
          end
        end
        STUFF: begin
          line_reg     <= line_toggle(line_reg);
          last_pending <= 1'b0;
          state        <= last_pending ? EOP_SE0_1 : DATA;
        end
        EOP_SE0_1: begin
          line_reg <= LINE_SE0;
          state    <= EOP_SE0_2;
        end
        EOP_SE0_2: begin
          line_reg <= LINE_SE0;
          state    <= EOP_J;
        end
        EOP_J: begin
          line_reg <= LINE_J;
          state    <= IDLE;
        end
        default: begin
          line_reg <= LINE_J;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
